// File: rtl/blit_pkg.sv
// Shared types and constants for the blitter loop sequencer.
package blit_pkg;

    // Pointer and counter word.
    typedef logic [15:0] word_t;

    // Sequencer phases.
    typedef enum logic [1:0] {
        IDLE = 2'd0,    // waiting for start
        SRC  = 2'd1,    // A2 read address presented
        DST  = 2'd2,    // A1 write address presented
        STEP = 2'd3     // per-line step applied to all pointers
    } blit_state_t;

    // Per-pixel pointer advance modes.
    localparam logic [1:0] XADD_PIX  = 2'b00;   // x + 1
    localparam logic [1:0] XADD_ZERO = 2'b01;   // no change
    localparam logic [1:0] XADD_NEG  = 2'b10;   // x - 1
    localparam logic [1:0] XADD_INC  = 2'b11;   // x + incx, y + incy

    // Number of pointer units (A1, A2).
    localparam int NUM_PTR = 2;
    localparam int PTR_A1  = 0;
    localparam int PTR_A2  = 1;

endpackage

// File: rtl/blit_loop_if.sv
// Handshake and address bus between the loop sequencer and the address generator / memory side.
interface blit_loop_if;
    import blit_pkg::*;

    logic  req;     // address valid (SRC or DST)
    logic  ack;     // memory accepted the current address
    logic  apipe;   // generator loads a new address
    logic  gena2;   // 1: address comes from A2
    word_t a1_x;
    word_t a1_y;
    word_t a2_x;
    word_t a2_y;

    // Sequencer side.
    modport master (
        output req,
        output apipe,
        output gena2,
        output a1_x,
        output a1_y,
        output a2_x,
        output a2_y,
        input  ack
    );

    // Generator / memory side.
    modport slave (
        input  req,
        input  apipe,
        input  gena2,
        input  a1_x,
        input  a1_y,
        input  a2_x,
        input  a2_y,
        output ack
    );

endinterface

// File: rtl/blit_ptr_step.sv
// One x/y pointer pair: initial load, per-pixel advance and per-line step.
module blit_ptr_step
    import blit_pkg::*;
(
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       load,
    input  logic       pix_en,
    input  logic       step_en,
    input  word_t      x0,
    input  word_t      y0,
    input  logic [1:0] xadd,
    input  word_t      incx,
    input  word_t      incy,
    input  word_t      stepx,
    input  word_t      stepy,
    output word_t      x,
    output word_t      y
);

    word_t x_reg;
    word_t y_reg;
    word_t x_next;
    word_t y_next;
    word_t pix_dx;
    word_t pix_dy;

    // Per-pixel delta selected by the advance mode; all arithmetic wraps modulo 2^16.
    always_comb begin
        pix_dx = 16'h0000;
        pix_dy = 16'h0000;
        case (xadd)
            XADD_PIX: begin
                pix_dx = 16'h0001;
            end
            XADD_ZERO: begin
                pix_dx = 16'h0000;
            end
            XADD_NEG: begin
                pix_dx = 16'hFFFF;
            end
            default: begin
                pix_dx = incx;
                pix_dy = incy;
            end
        endcase
    end

    // Next pointer value; the controller never asserts more than one enable at a time.
    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (load) begin
            x_next = x0;
            y_next = y0;
        end else if (step_en) begin
            x_next = x_reg + stepx;
            y_next = y_reg + stepy;
        end else if (pix_en) begin
            x_next = x_reg + pix_dx;
            y_next = y_reg + pix_dy;
        end
    end

    // Pointer registers.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            x_reg <= 16'h0000;
            y_reg <= 16'h0000;
        end else begin
            x_reg <= x_next;
            y_reg <= y_next;
        end
    end

    assign x = x_reg;
    assign y = y_reg;

endmodule

// File: rtl/blit_loop.sv
// Blitter loop sequencer: inner/outer loop counters, SRC/DST/STEP phasing and A1/A2 pointer stepping.
module blit_loop
    import blit_pkg::*;
(
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          clk,
    input  logic          start,
    input  word_t         inner_cnt,
    input  word_t         outer_cnt,
    input  word_t         a1_x0,
    input  word_t         a1_y0,
    input  word_t         a2_x0,
    input  word_t         a2_y0,
    input  logic [1:0]    a1_xadd,
    input  logic [1:0]    a2_xadd,
    input  word_t         a1_incx,
    input  word_t         a1_incy,
    input  word_t         a2_incx,
    input  word_t         a2_incy,
    input  word_t         a1_stepx,
    input  word_t         a1_stepy,
    input  word_t         a2_stepx,
    input  word_t         a2_stepy,
    blit_loop_if.master   bus,
    output logic          busy,
    output logic          done
);

    blit_state_t state_reg;
    word_t       icnt_reg;
    word_t       ocnt_reg;
    logic        clk_d_reg;
    logic        req_reg;
    logic        gena2_reg;
    logic        apipe_reg;
    logic        busy_reg;
    logic        done_reg;

    logic        tick;
    logic        counts_zero;
    logic        load_en;
    logic        pix_en;
    logic        step_en;

    // Per-pointer operand arrays, indexed PTR_A1 / PTR_A2.
    word_t       x0_arr    [NUM_PTR];
    word_t       y0_arr    [NUM_PTR];
    logic [1:0]  xadd_arr  [NUM_PTR];
    word_t       incx_arr  [NUM_PTR];
    word_t       incy_arr  [NUM_PTR];
    word_t       stepx_arr [NUM_PTR];
    word_t       stepy_arr [NUM_PTR];
    word_t       x_arr     [NUM_PTR];
    word_t       y_arr     [NUM_PTR];

    // Phase strobe edge detector: a tick is the first sys_clk edge that sees clk high.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            clk_d_reg <= 1'b0;
        end else begin
            clk_d_reg <= clk;
        end
    end

    assign tick        = clk & ~clk_d_reg;
    assign counts_zero = (inner_cnt == 16'h0000) || (outer_cnt == 16'h0000);

    // Pointer control strobes, all qualified by tick so pointers move only on phase edges.
    always_comb begin
        load_en = 1'b0;
        pix_en  = 1'b0;
        step_en = 1'b0;
        if (tick) begin
            case (state_reg)
                IDLE:    load_en = start && !counts_zero;
                DST:     pix_en  = bus.ack;
                STEP:    step_en = 1'b1;
                default: ;
            endcase
        end
    end

    assign x0_arr[PTR_A1]    = a1_x0;
    assign y0_arr[PTR_A1]    = a1_y0;
    assign xadd_arr[PTR_A1]  = a1_xadd;
    assign incx_arr[PTR_A1]  = a1_incx;
    assign incy_arr[PTR_A1]  = a1_incy;
    assign stepx_arr[PTR_A1] = a1_stepx;
    assign stepy_arr[PTR_A1] = a1_stepy;

    assign x0_arr[PTR_A2]    = a2_x0;
    assign y0_arr[PTR_A2]    = a2_y0;
    assign xadd_arr[PTR_A2]  = a2_xadd;
    assign incx_arr[PTR_A2]  = a2_incx;
    assign incy_arr[PTR_A2]  = a2_incy;
    assign stepx_arr[PTR_A2] = a2_stepx;
    assign stepy_arr[PTR_A2] = a2_stepy;

    // Both pointers advance together on every accepted DST, so they share the same strobes.
    generate
        for (genvar gi = 0; gi < NUM_PTR; gi++) begin : g_ptr
            blit_ptr_step u_ptr (
                .sys_clk (sys_clk),
                .reset   (reset),
                .load    (load_en),
                .pix_en  (pix_en),
                .step_en (step_en),
                .x0      (x0_arr[gi]),
                .y0      (y0_arr[gi]),
                .xadd    (xadd_arr[gi]),
                .incx    (incx_arr[gi]),
                .incy    (incy_arr[gi]),
                .stepx   (stepx_arr[gi]),
                .stepy   (stepy_arr[gi]),
                .x       (x_arr[gi]),
                .y       (y_arr[gi])
            );
        end
    endgenerate

    // Loop sequencer with registered outputs; done is a single-cycle pulse and apipe
    // is cleared by the first tick after a phase is entered.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_reg <= IDLE;
            icnt_reg  <= 16'h0000;
            ocnt_reg  <= 16'h0000;
            req_reg   <= 1'b0;
            gena2_reg <= 1'b0;
            apipe_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (tick) begin
                apipe_reg <= 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            if (counts_zero) begin
                                done_reg <= 1'b1;
                            end else begin
                                icnt_reg  <= inner_cnt;
                                ocnt_reg  <= outer_cnt;
                                state_reg <= SRC;
                                req_reg   <= 1'b1;
                                gena2_reg <= 1'b1;
                                apipe_reg <= 1'b1;
                                busy_reg  <= 1'b1;
                            end
                        end
                    end
                    SRC: begin
                        if (bus.ack) begin
                            state_reg <= DST;
                            req_reg   <= 1'b1;
                            gena2_reg <= 1'b0;
                            apipe_reg <= 1'b1;
                        end
                    end
                    DST: begin
                        if (bus.ack) begin
                            if (icnt_reg > 16'h0001) begin
                                icnt_reg  <= icnt_reg - 16'h0001;
                                state_reg <= SRC;
                                req_reg   <= 1'b1;
                                gena2_reg <= 1'b1;
                                apipe_reg <= 1'b1;
                            end else if (ocnt_reg > 16'h0001) begin
                                state_reg <= STEP;
                                req_reg   <= 1'b0;
                                gena2_reg <= 1'b0;
                            end else begin
                                state_reg <= IDLE;
                                req_reg   <= 1'b0;
                                gena2_reg <= 1'b0;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end
                        end
                    end
                    STEP: begin
                        ocnt_reg  <= ocnt_reg - 16'h0001;
                        icnt_reg  <= inner_cnt;
                        state_reg <= SRC;
                        req_reg   <= 1'b1;
                        gena2_reg <= 1'b1;
                        apipe_reg <= 1'b1;
                    end
                    default: begin
                        state_reg <= IDLE;
                        req_reg   <= 1'b0;
                        gena2_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.req   = req_reg;
    assign bus.gena2 = gena2_reg;
    assign bus.apipe = apipe_reg;
    assign bus.a1_x  = x_arr[PTR_A1];
    assign bus.a1_y  = y_arr[PTR_A1];
    assign bus.a2_x  = x_arr[PTR_A2];
    assign bus.a2_y  = y_arr[PTR_A2];
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_blit_loop.sv
// Directed bench for blit_loop: loop sequencing, pointer modes, wait states, zero counts and reset abort.
module tb_blit_loop;
    import blit_pkg::*;

    logic       sys_clk;
    logic       reset;
    logic       clk;
    logic       start;
    word_t      inner_cnt, outer_cnt;
    word_t      a1_x0, a1_y0, a2_x0, a2_y0;
    logic [1:0] a1_xadd, a2_xadd;
    word_t      a1_incx, a1_incy, a2_incx, a2_incy;
    word_t      a1_stepx, a1_stepy, a2_stepx, a2_stepy;
    logic       busy, done;

    int checks   = 0;
    int failures = 0;

    blit_loop_if bus ();

    blit_loop dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .clk       (clk),
        .start     (start),
        .inner_cnt (inner_cnt),
        .outer_cnt (outer_cnt),
        .a1_x0     (a1_x0),
        .a1_y0     (a1_y0),
        .a2_x0     (a2_x0),
        .a2_y0     (a2_y0),
        .a1_xadd   (a1_xadd),
        .a2_xadd   (a2_xadd),
        .a1_incx   (a1_incx),
        .a1_incy   (a1_incy),
        .a2_incx   (a2_incx),
        .a2_incy   (a2_incy),
        .a1_stepx  (a1_stepx),
        .a1_stepy  (a1_stepy),
        .a2_stepx  (a2_stepx),
        .a2_stepy  (a2_stepy),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    // sys_clk rises at 5,15,25...; the phase strobe rises at 10,30,50... so ticks land on 15,35,55...
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        clk = 1'b0;
        #10 clk = 1'b1;
        forever #10 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next tick edge.
    task automatic tk();
        @(posedge clk);
        @(posedge sys_clk);
        #1;
    endtask

    // Advance one plain sys_clk edge.
    task automatic sc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_defaults();
        start     = 1'b0;
        bus.ack   = 1'b0;
        inner_cnt = 16'h0000;
        outer_cnt = 16'h0000;
        a1_x0 = 16'h0000; a1_y0 = 16'h0000; a2_x0 = 16'h0000; a2_y0 = 16'h0000;
        a1_xadd = XADD_ZERO; a2_xadd = XADD_ZERO;
        a1_incx = 16'h0000; a1_incy = 16'h0000; a2_incx = 16'h0000; a2_incy = 16'h0000;
        a1_stepx = 16'h0000; a1_stepy = 16'h0000; a2_stepx = 16'h0000; a2_stepy = 16'h0000;
    endtask

    task automatic show(input string name);
        $display("blit %s: a1=(%h,%h) a2=(%h,%h) busy=%0b", name,
                 bus.a1_x, bus.a1_y, bus.a2_x, bus.a2_y, busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_defaults();
        reset = 1'b1;
        repeat (4) sc();
        reset = 1'b0;

        // Reset state
        check_val("rst_req",   16'(bus.req),   16'd0);
        check_val("rst_busy",  16'(busy),      16'd0);
        check_val("rst_done",  16'(done),      16'd0);
        check_val("rst_apipe", 16'(bus.apipe), 16'd0);
        check_val("rst_gena2", 16'(bus.gena2), 16'd0);
        check_val("rst_a1x",   bus.a1_x,       16'h0000);

        // 1) inner=3 outer=1, +1 per pixel, ack every tick
        inner_cnt = 16'd3; outer_cnt = 16'd1;
        a1_x0 = 16'h0010; a2_x0 = 16'h0010;
        a1_xadd = XADD_PIX; a2_xadd = XADD_PIX;
        bus.ack = 1'b1;
        start = 1'b1;
        tk();
        start = 1'b0;
        for (int p = 0; p < 3; p++) begin
            check_val("t1_src_req",   16'(bus.req),   16'd1);
            check_val("t1_src_gena2", 16'(bus.gena2), 16'd1);
            check_val("t1_src_apipe", 16'(bus.apipe), 16'd1);
            check_val("t1_src_a2x",   bus.a2_x,       16'h0010 + 16'(p));
            check_val("t1_src_done",  16'(done),      16'd0);
            tk();
            check_val("t1_dst_req",   16'(bus.req),   16'd1);
            check_val("t1_dst_gena2", 16'(bus.gena2), 16'd0);
            check_val("t1_dst_apipe", 16'(bus.apipe), 16'd1);
            tk();
        end
        check_val("t1_end_done", 16'(done),    16'd1);
        check_val("t1_end_busy", 16'(busy),    16'd0);
        check_val("t1_end_req",  16'(bus.req), 16'd0);
        check_val("t1_end_a1x",  bus.a1_x,     16'h0013);
        check_val("t1_end_a2x",  bus.a2_x,     16'h0013);
        show("t1");
        sc();
        check_val("t1_done_pulse", 16'(done), 16'd0);

        // 2) inner=2 outer=2 with per-line step
        set_defaults();
        inner_cnt = 16'd2; outer_cnt = 16'd2;
        a1_x0 = 16'h0010; a1_y0 = 16'h0020; a1_xadd = XADD_PIX;
        a1_stepx = 16'hFFFE; a1_stepy = 16'h0001;
        a2_x0 = 16'h0100; a2_xadd = XADD_ZERO; a2_stepx = 16'h0003;
        bus.ack = 1'b1;
        start = 1'b1;
        tk();
        start = 1'b0;
        tk(); tk(); tk(); tk();
        check_val("t2_step_req",  16'(bus.req),   16'd0);
        check_val("t2_step_busy", 16'(busy),      16'd1);
        check_val("t2_step_a1x",  bus.a1_x,       16'h0012);
        tk();
        check_val("t2_l2_a1x",   bus.a1_x,       16'h0010);
        check_val("t2_l2_a1y",   bus.a1_y,       16'h0021);
        check_val("t2_l2_a2x",   bus.a2_x,       16'h0103);
        check_val("t2_l2_gena2", 16'(bus.gena2), 16'd1);
        check_val("t2_l2_apipe", 16'(bus.apipe), 16'd1);
        tk(); tk(); tk();
        check_val("t2_mid_done", 16'(done), 16'd0);
        tk();
        check_val("t2_end_done", 16'(done), 16'd1);
        check_val("t2_end_a1x",  bus.a1_x,  16'h0012);
        check_val("t2_end_a1y",  bus.a1_y,  16'h0021);
        show("t2");

        // 3) A2 increment mode with x wrap
        set_defaults();
        inner_cnt = 16'd2; outer_cnt = 16'd1;
        a2_x0 = 16'h0000; a2_y0 = 16'h0005;
        a2_xadd = XADD_INC; a2_incx = 16'hFFFF; a2_incy = 16'h0002;
        bus.ack = 1'b1;
        start = 1'b1;
        tk();
        start = 1'b0;
        check_val("t3_a2x0", bus.a2_x, 16'h0000);
        tk(); tk();
        check_val("t3_p1_a2x", bus.a2_x, 16'hFFFF);
        check_val("t3_p1_a2y", bus.a2_y, 16'h0007);
        tk(); tk();
        check_val("t3_p2_a2x", bus.a2_x, 16'hFFFE);
        check_val("t3_p2_a2y", bus.a2_y, 16'h0009);
        check_val("t3_done",   16'(done), 16'd1);
        show("t3");

        // 4) ack held low in SRC for 5 ticks
        set_defaults();
        inner_cnt = 16'd1; outer_cnt = 16'd1;
        a1_x0 = 16'h0040; a1_xadd = XADD_PIX;
        bus.ack = 1'b0;
        start = 1'b1;
        tk();
        start = 1'b0;
        check_val("t4_entry_apipe", 16'(bus.apipe), 16'd1);
        sc();
        check_val("t4_hold_apipe", 16'(bus.apipe), 16'd1);
        for (int w = 0; w < 5; w++) begin
            tk();
            check_val("t4_wait_req",   16'(bus.req),   16'd1);
            check_val("t4_wait_apipe", 16'(bus.apipe), 16'd0);
            check_val("t4_wait_gena2", 16'(bus.gena2), 16'd1);
            check_val("t4_wait_a1x",   bus.a1_x,       16'h0040);
        end
        bus.ack = 1'b1;
        tk();
        check_val("t4_dst_gena2", 16'(bus.gena2), 16'd0);
        check_val("t4_dst_apipe", 16'(bus.apipe), 16'd1);
        tk();
        check_val("t4_end_done", 16'(done), 16'd1);
        check_val("t4_end_a1x",  bus.a1_x,  16'h0041);
        show("t4");

        // 5) zero count start, then start while busy
        set_defaults();
        inner_cnt = 16'd0; outer_cnt = 16'd5;
        start = 1'b1;
        tk();
        start = 1'b0;
        check_val("t5_zero_done", 16'(done),    16'd1);
        check_val("t5_zero_req",  16'(bus.req), 16'd0);
        check_val("t5_zero_busy", 16'(busy),    16'd0);
        sc();
        check_val("t5_zero_pulse", 16'(done), 16'd0);
        inner_cnt = 16'd3; outer_cnt = 16'd0;
        start = 1'b1;
        tk();
        start = 1'b0;
        check_val("t5_ozero_done", 16'(done),    16'd1);
        check_val("t5_ozero_req",  16'(bus.req), 16'd0);
        show("t5_zero");

        inner_cnt = 16'd2; outer_cnt = 16'd1;
        a1_x0 = 16'h0050; a1_xadd = XADD_PIX;
        bus.ack = 1'b1;
        start = 1'b1;
        tk();
        a1_x0 = 16'h0099;
        tk(); tk();
        check_val("t5_busy_a1x",   bus.a1_x,       16'h0051);
        check_val("t5_busy_gena2", 16'(bus.gena2), 16'd1);
        start = 1'b0;
        tk(); tk();
        check_val("t5_busy_done", 16'(done), 16'd1);
        check_val("t5_busy_end",  bus.a1_x,  16'h0052);
        show("t5_busy");

        // 6) reset in DST with outer=4
        set_defaults();
        inner_cnt = 16'd2; outer_cnt = 16'd4;
        a1_x0 = 16'h0033; a1_xadd = XADD_PIX;
        bus.ack = 1'b1;
        start = 1'b1;
        tk();
        start = 1'b0;
        tk();
        check_val("t6_in_dst", 16'(bus.gena2), 16'd0);
        reset = 1'b1;
        sc();
        check_val("t6_req",   16'(bus.req),   16'd0);
        check_val("t6_busy",  16'(busy),      16'd0);
        check_val("t6_done",  16'(done),      16'd0);
        check_val("t6_apipe", 16'(bus.apipe), 16'd0);
        check_val("t6_a1x",   bus.a1_x,       16'h0000);
        reset = 1'b0;
        tk();
        check_val("t6_after_busy", 16'(busy), 16'd0);
        check_val("t6_after_done", 16'(done), 16'd0);
        show("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/blit_loop.md
# blit_loop

Blitter loop sequencer and pointer stepper, directly upstream of the address generator. It runs the inner (pixel) and outer (line) loop counters and holds and steps the A1 and A2 x/y pointers. It drives the generator's a1_x/a1_y/a2_x/a2_y, gena2 and apipe inputs, and handshakes each generated address with the memory interface via req/ack.

## Interface
- No parameters; all widths fixed.
- sys_clk  in  1  system clock; all flops clock on its rising edge.
- reset  in  1  synchronous, active-high reset.
- clk  in  1  blitter phase strobe; tick = clk high while its value on the previous sys_clk edge was low.
- start  in  1  begin a blit; sampled on tick in IDLE only.
- inner_cnt, outer_cnt  in  16 each  pixels per line, lines per blit.
- a1_x0, a1_y0, a2_x0, a2_y0  in  16 each  initial pointers.
- a1_xadd, a2_xadd  in  2 each  per-pixel mode: 00 +1 on x; 01 +0; 10 −1 on x; 11 add inc registers to x and y.
- a1_incx, a1_incy, a2_incx, a2_incy  in  16 each  increment values used by mode 11.
- a1_stepx, a1_stepy, a2_stepx, a2_stepy  in  16 each  per-line step values.
- ack  in  1  memory accepted the current address; sampled on tick.
- a1_x, a1_y, a2_x, a2_y  out  16 each  current pointers.
- gena2  out  1  1 in SRC (address from A2), 0 otherwise.
- apipe  out  1  address generator should load a new address.
- req  out  1  address valid; high in SRC and DST.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one sys_clk pulse at completion.

## Operation
- States:
  - IDLE: wait for start.
  - SRC: A2 read.
  - DST: A1 write.
  - STEP: apply the per-line step.
- All state and register updates happen only on tick, except `done` and `apipe` clearing (see Timing).
- IDLE, tick & start:
  - If inner_cnt==0 or outer_cnt==0: pulse done and stay in IDLE; no req is issued.
  - Otherwise: load the pointers from the *_0 inputs, load icnt=inner_cnt and ocnt=outer_cnt, and go to SRC.
- SRC, tick & ack: go to DST.
- DST, tick & ack:
  - Apply each pointer's xadd to A1 and A2.
  - If icnt>1: decrement icnt and go to SRC.
  - Else if ocnt>1: go to STEP.
  - Else: go to IDLE and pulse done.
- STEP, one tick:
  - Add the step values to all four pointers.
  - Decrement ocnt, reload icnt=inner_cnt, go to SRC.
- The per-pixel increment is also applied after the last pixel of a line; the step values compensate for it.
- Arithmetic is 16-bit two's complement and wraps modulo 2^16. No saturation.
- start while busy is ignored. ack in IDLE or STEP is ignored.
- Inputs other than start/ack are read only at load (counts and *_0) or when used. Changing them mid-blit takes effect at their next use.

## Timing
- Reset values: state IDLE, pointers 0, icnt and ocnt 0, gena2 0, apipe 0, req 0, busy 0, done 0.
- Reset asserted mid-blit aborts within one sys_clk: no done pulse, req drops on the next edge.
- Start accepted on tick N gives SRC with req=1 and gena2=1 from the sys_clk edge of tick N.
- ack is sampled no earlier than the tick after phase entry. Minimum of 2 ticks per pixel.
- apipe is set on entry to SRC or DST and cleared at the next tick's edge. This makes the generator register the new address exactly once per phase and hold it during ack wait states.
- done is high for exactly one sys_clk cycle, on the edge of the tick that enters IDLE (or rejects a zero-count start).
- Pointer updates are visible on the edge of the tick at which ack is accepted in DST, before the next SRC.

## Structure
- Shared package blit_pkg holds:
  - the state enum (IDLE, SRC, DST, STEP);
  - the xadd codes XADD_PIX=2'b00, XADD_ZERO=2'b01, XADD_NEG=2'b10, XADD_INC=2'b11.
- Sub-module blit_ptr_step:
  - one instance per pointer (A1, A2);
  - holds the x/y registers, the xadd mux, and the step adder;
  - control inputs: load, pix_en, step_en.

## Test plan
- Reset then start with inner=3, outer=1, a1_x0=a2_x0=0x0010, xadd 00, ack every tick -> req alternates SRC/DST for 3 pixels; a2_x shows 0x10, 0x11, 0x12 in SRC; done is one cycle; final a1_x=0x0013.
- inner=2, outer=2, a1_xadd=00, a1_stepx=0xFFFE, a1_stepy=1 -> second line starts at a1_x=0x0010, a1_y=y0+1.
- a2_xadd=11, incx=0xFFFF, incy=2, a2_x0=0 -> pointer wraps to 0xFFFF, y advances by 2 per pixel.
- ack held low 5 ticks in SRC -> req stays high, apipe high only until the first tick, pointers unchanged.
- start with inner=0 -> done pulse, no req; start asserted while busy -> ignored.
- Reset asserted in DST with outer=4 -> next edge IDLE, all outputs 0, no done.
